// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with a single-outstanding req/gnt/rvalid fetch port and the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;
  state_t      state;
  logic [31:0] pc, pc_fly, hold_instr, hold_pc, tgt, fly4;
  logic        hold_v, acc, wr_new, wr_hold;
  assign imem_req  = (state == REQ) && !StallF;
  assign imem_addr = pc;
  assign acc       = imem_req && imem_gnt;
  assign tgt       = PCTargetE & ~32'h3;
  assign fly4      = pc_fly + 32'd4;
  assign wr_new    = (state == WAIT) && imem_rvalid && !PCSrcE && !FlushD && !StallD;
  assign wr_hold   = (state == HOLD) && hold_v && !PCSrcE && !FlushD && !StallD;
  // A redirect always wins; a request already granted for the old PC turns into a stale one (DROP).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= REQ;
      pc         <= RESET_PC;
      pc_fly     <= RESET_PC;
      hold_v     <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'd0;
    end else begin
      case (state)
        REQ:
          if (PCSrcE) begin
            pc <= tgt;
            if (acc) state <= DROP;
          end else if (acc) begin
            pc_fly <= pc;
            state  <= WAIT;
          end
        WAIT:
          if (PCSrcE) begin
            pc    <= tgt;
            state <= imem_rvalid ? REQ : DROP;
          end else if (imem_rvalid) begin
            pc <= fly4;
            if (StallD && !FlushD) begin
              hold_v     <= 1'b1;
              hold_instr <= imem_rdata;
              hold_pc    <= pc_fly;
              state      <= HOLD;
            end else state <= REQ;
          end
        HOLD:
          if (PCSrcE) begin
            pc     <= tgt;
            hold_v <= 1'b0;
            state  <= REQ;
          end else if (!StallD) begin
            hold_v <= 1'b0;
            state  <= REQ;
          end
        default: begin
          if (PCSrcE) pc <= tgt;
          if (imem_rvalid) state <= REQ;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (wr_new) begin
      InstrD   <= imem_rdata;
      PCD      <= pc_fly;
      PCPlus4D <= fly4;
      ValidD   <= 1'b1;
    end else if (wr_hold) begin
      InstrD   <= hold_instr;
      PCD      <= hold_pc;
      PCPlus4D <= hold_pc + 32'd4;
      ValidD   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed per-cycle vectors plus a mid-transaction reset sequence for fetch_stage.
module tb_fetch_stage;
  logic        clk = 0, rst = 0;
  logic        StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0;
  logic [31:0] PCTargetE = 0;
  logic        imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] imem_addr, imem_rdata = 0, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  int          n_cmp = 0, n_bad = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sf, sd, fd, pcs;
    logic [31:0] tgt;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr, instr, pcd, pc4;
    logic        vd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic sf, input logic sd, input logic fd, input logic pcs,
                              input logic [31:0] tgt, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic req, input logic [31:0] addr,
                              input logic [31:0] instr, input logic [31:0] pcd,
                              input logic [31:0] pc4, input logic vd);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fd = fd; v.pcs = pcs; v.tgt = tgt; v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.req = req; v.addr = addr; v.instr = instr; v.pcd = pcd; v.pc4 = pc4; v.vd = vd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pcd,
                          input logic [31:0] pc4, input logic vd);
    chk({tag, " InstrD"}, InstrD, instr);
    chk({tag, " PCD"}, PCD, pcd);
    chk({tag, " PCPlus4D"}, PCPlus4D, pc4);
    chk({tag, " ValidD"}, {31'd0, ValidD}, {31'd0, vd});
  endtask

  task automatic drive(input vec_t v);
    StallF = v.sf; StallD = v.sd; FlushD = v.fd; PCSrcE = v.pcs; PCTargetE = v.tgt;
    imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rdata;
  endtask

  initial begin
    vec_t z;
    z = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    //      sf sd fd pcs tgt           gnt rv rdata         req addr          instr         pcd           pc4           vd
    vq.push_back(mk(0,0,0,0,32'h0,        1,0,32'h0,        1,32'h0,        32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,0,0,32'h0,        0,1,32'h00500093, 0,32'h0,        32'h00500093, 32'h0,        32'h4,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        1,0,32'h0,        1,32'h4,        32'h00500093, 32'h0,        32'h4,        1));
    vq.push_back(mk(0,1,0,0,32'h0,        0,1,32'h00000463, 0,32'h4,        32'h00500093, 32'h0,        32'h4,        1));
    vq.push_back(mk(0,1,0,0,32'h0,        0,0,32'h0,        0,32'h8,        32'h00500093, 32'h0,        32'h4,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        0,0,32'h0,        0,32'h8,        32'h00000463, 32'h4,        32'h8,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        0,0,32'h0,        1,32'h8,        32'h00000463, 32'h4,        32'h8,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        0,0,32'h0,        1,32'h8,        32'h00000463, 32'h4,        32'h8,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        0,0,32'h0,        1,32'h8,        32'h00000463, 32'h4,        32'h8,        1));
    vq.push_back(mk(1,0,0,0,32'h0,        1,0,32'h0,        0,32'h8,        32'h00000463, 32'h4,        32'h8,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        1,0,32'h0,        1,32'h8,        32'h00000463, 32'h4,        32'h8,        1));
    vq.push_back(mk(0,0,0,1,32'h102,      0,0,32'h0,        0,32'h8,        32'h00000463, 32'h4,        32'h8,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        0,1,32'hdeadbeef, 0,32'h100,      32'h00000463, 32'h4,        32'h8,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        1,0,32'h0,        1,32'h100,      32'h00000463, 32'h4,        32'h8,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        0,1,32'h00a00113, 0,32'h100,      32'h00a00113, 32'h100,      32'h104,      1));
    vq.push_back(mk(0,0,1,0,32'h0,        0,0,32'h0,        1,32'h104,      32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,0,0,32'h0,        1,0,32'h0,        1,32'h104,      32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,0,0,32'h0,        0,1,32'h00108093, 0,32'h104,      32'h00108093, 32'h104,      32'h108,      1));
    vq.push_back(mk(0,1,1,0,32'h0,        0,0,32'h0,        1,32'h108,      32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,0,0,32'h0,        1,0,32'h0,        1,32'h108,      32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,1,1,32'h200,      0,1,32'h11111111, 0,32'h108,      32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,0,1,32'h300,      1,0,32'h0,        1,32'h200,      32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,0,0,32'h0,        0,1,32'h22222222, 0,32'h300,      32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,0,1,32'hffffffff, 0,0,32'h0,        1,32'h300,      32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,0,0,32'h0,        1,0,32'h0,        1,32'hfffffffc, 32'h13,       32'h0,        32'h0,        0));
    vq.push_back(mk(0,0,0,0,32'h0,        0,1,32'h00000033, 0,32'hfffffffc, 32'h00000033, 32'hfffffffc, 32'h0,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        0,1,32'h44444444, 1,32'h0,        32'h00000033, 32'hfffffffc, 32'h0,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        1,0,32'h0,        1,32'h0,        32'h00000033, 32'hfffffffc, 32'h0,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        0,1,32'h00300093, 0,32'h0,        32'h00300093, 32'h0,        32'h4,        1));
    vq.push_back(mk(0,0,0,0,32'h0,        1,0,32'h0,        1,32'h4,        32'h00300093, 32'h0,        32'h4,        1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset imem_req", {31'd0, imem_req}, 32'd1);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk_ifid("reset", 32'h13, 32'h0, 32'h0, 0);
    @(negedge clk) rst = 1;

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, vq[i].req});
      chk({tag, " imem_addr"}, imem_addr, vq[i].addr);
      @(posedge clk);
      #1;
      chk_ifid(tag, vq[i].instr, vq[i].pcd, vq[i].pc4, vq[i].vd);
    end

    // Reset asserted while a fetch is in WAIT, then a stale response after release.
    @(negedge clk);
    drive(z);
    rst = 0;
    #1;
    chk("midrst imem_req", {31'd0, imem_req}, 32'd1);
    chk("midrst imem_addr", imem_addr, 32'h0);
    chk_ifid("midrst", 32'h13, 32'h0, 32'h0, 0);
    @(negedge clk) rst = 1;
    imem_rvalid = 1; imem_rdata = 32'h55555555;
    @(posedge clk);
    #1;
    chk_ifid("stale", 32'h13, 32'h0, 32'h0, 0);
    @(negedge clk);
    drive(z);
    imem_gnt = 1;
    #1;
    chk("postrst imem_req", {31'd0, imem_req}, 32'd1);
    chk("postrst imem_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    drive(z);
    imem_rvalid = 1; imem_rdata = 32'h00700193;
    @(posedge clk);
    #1;
    chk_ifid("postrst fetch", 32'h00700193, 32'h0, 32'h4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
